// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end between the synchronous instruction
// ROM and the decode stage. A PC generator issues ROM reads under a credit rule.
// Each response is written, together with its PC, into a small circular queue.
// Decode pops entries from that queue. A redirect flushes the queue and the
// in-flight read, then restarts fetching at the new address.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   : when the queue is empty, an arriving ROM response drives
//               instrD/pcD/instr_valid directly in its arrival cycle
//               (1-cycle fetch latency).
//   undefined : outputs come only from queue registers (2-cycle fetch latency).
//               There is no combinational path from imem_rdata to the outputs.

module fetch_queue #(
    parameter int INSTR_W  = 24,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic                       imem_en,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [INSTR_W-1:0]         instrD,
    output logic [ADDR_W-1:0]          pcD,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CRD_W = CNT_W + 1;

    logic [ADDR_W-1:0]  pc_q;
    logic               inflight_q;
    logic [ADDR_W-1:0]  inflight_pc_q;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               head_valid;
    logic               bypass_hit;
    logic               pop;
    logic               queue_pop;
    logic               push;
    logic               issue;
    logic [CRD_W-1:0]   credit_used;

    assign head_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = inflight_q & ~redirect & ~head_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    // Head presentation: the queue head if there is one, otherwise (bypass only) the arriving response.
    always_comb begin
        instr_valid = head_valid | bypass_hit;
        instrD      = '0;
        pcD         = '0;
        if (head_valid) begin
            instrD = instr_mem[rd_ptr_q];
            pcD    = pc_mem[rd_ptr_q];
        end else if (bypass_hit) begin
            instrD = imem_rdata;
            pcD    = inflight_pc_q;
        end
    end

    // Redirect wins over decode acceptance, so a redirect cycle never consumes the head.
    assign pop       = instr_valid & ~stall & ~redirect;
    assign queue_pop = pop & head_valid;

    // A bypassed response that decode takes right away is never written to the queue.
    assign push = inflight_q & ~redirect & ~(bypass_hit & pop);

    // Credits cover stored entries plus the read still in flight. This cycle's pop frees one slot early.
    assign credit_used = {1'b0, count_q} + CRD_W'(inflight_q) - CRD_W'(pop);
    assign issue       = ~redirect & (credit_used < CRD_W'(DEPTH));

    assign imem_en   = ~reset & issue;
    assign imem_addr = pc_q;
    assign count     = count_q;

    // PC generator plus the one-deep shadow of the outstanding read's address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + ADDR_W'(1);
            end
        end
    end

    // Queue bookkeeping. A redirect drops every entry and any response arriving in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (queue_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(queue_pop);
        end
    end

    // Entry storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
// A queue-based reference model is compared every cycle. A hand-computed vector
// table covers start-up, stall/credit exhaustion and redirect timing. Further
// hand sequences cover PC wrap and an asynchronous reset with the queue full.
// Compile with +define+FETCH_BYPASS_EN to check the bypass build.

module tb_fetch_queue;

    localparam int INSTR_W  = 24;
    localparam int ADDR_W   = 16;
    localparam int DEPTH    = 4;
    localparam int RESET_PC = 0;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic               clk;
    logic               reset;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] instrD;
    logic [ADDR_W-1:0]  pcD;
    logic               instr_valid;
    logic [CNT_W-1:0]   count;

    fetch_queue #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_en    (imem_en),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instrD     (instrD),
        .pcD        (pcD),
        .instr_valid(instr_valid),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: stored PCs in queue order, plus the one outstanding read.
    logic [ADDR_W-1:0] mq[$];
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_inf_pc;
    bit                m_inf;

    // DUT outputs observed in the last applied cycle
    logic              obs_valid;
    logic [ADDR_W-1:0] obs_pcd;
    logic [CNT_W-1:0]  obs_count;
    logic              obs_en;

    typedef struct {
        bit                s;
        bit                r;
        logic [ADDR_W-1:0] rpc;
        bit                v;
        logic [ADDR_W-1:0] pcd;
        int                cnt;
        bit                en;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [INSTR_W-1:0] rom(input logic [ADDR_W-1:0] a);
        return 24'h100000 + {8'h00, a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_inf    = 1'b0;
        m_inf_pc = '0;
        m_pc     = ADDR_W'(RESET_PC);
    endtask

    // One clock cycle: drive inputs, compare against the model, clock, answer the ROM read.
    task automatic applyStimulus(input bit s, input bit r, input logic [ADDR_W-1:0] rpc);
        bit                byp;
        bit                valid;
        bit                pop;
        bit                en;
        int                used;
        logic [ADDR_W-1:0] hpc;
        logic              dut_en;
        logic [ADDR_W-1:0] dut_addr;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = m_inf && !r && (mq.size() == 0);
`endif
        valid = (mq.size() > 0) || byp;
        hpc   = (mq.size() > 0) ? mq[0] : m_inf_pc;
        pop   = valid && !s && !r;
        used  = mq.size() + int'(m_inf) - int'(pop);
        en    = !r && (used < DEPTH);
        checkOutput("instr_valid", 32'(instr_valid), 32'(valid));
        checkOutput("pcD", 32'(pcD), valid ? 32'(hpc) : 32'd0);
        checkOutput("instrD", 32'(instrD), valid ? 32'(rom(hpc)) : 32'd0);
        checkOutput("count", 32'(count), 32'(mq.size()));
        checkOutput("imem_en", 32'(imem_en), 32'(en));
        checkOutput("imem_addr", 32'(imem_addr), 32'(m_pc));
        obs_valid = instr_valid;
        obs_pcd   = pcD;
        obs_count = count;
        obs_en    = imem_en;
        dut_en    = imem_en;
        dut_addr  = imem_addr;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_inf = 1'b0;
            m_pc  = rpc;
        end else begin
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (m_inf && !(byp && pop)) mq.push_back(m_inf_pc);
            m_inf = en;
            if (en) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + ADDR_W'(1);
            end
        end
        #1;
        imem_rdata = dut_en ? rom(dut_addr) : INSTR_W'($urandom);
        cyc++;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
        checkOutput({tag, " count"}, 32'(count), 32'd0);
        checkOutput({tag, " instrD"}, 32'(instrD), 32'd0);
        checkOutput({tag, " pcD"}, 32'(pcD), 32'd0);
        checkOutput({tag, " imem_en"}, 32'(imem_en), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] seen[$];
        logic [ADDR_W-1:0] wrap_exp[4];
        bit s;
        bit r;
        logic [ADDR_W-1:0] rpc;

`ifdef FETCH_BYPASS_EN
        tbl[0]  = '{0, 0, 16'h0000, 0, 16'h0000, 0, 1};
        tbl[1]  = '{0, 0, 16'h0000, 1, 16'h0000, 0, 1};
        tbl[2]  = '{0, 0, 16'h0000, 1, 16'h0001, 0, 1};
        tbl[3]  = '{0, 0, 16'h0000, 1, 16'h0002, 0, 1};
        tbl[4]  = '{1, 0, 16'h0000, 1, 16'h0003, 0, 1};
        tbl[5]  = '{1, 0, 16'h0000, 1, 16'h0003, 1, 1};
        tbl[6]  = '{1, 0, 16'h0000, 1, 16'h0003, 2, 1};
        tbl[7]  = '{1, 0, 16'h0000, 1, 16'h0003, 3, 0};
        tbl[8]  = '{0, 0, 16'h0000, 1, 16'h0003, 4, 1};
        tbl[9]  = '{0, 0, 16'h0000, 1, 16'h0004, 3, 1};
        tbl[10] = '{0, 0, 16'h0000, 1, 16'h0005, 3, 1};
        tbl[11] = '{0, 1, 16'h0040, 1, 16'h0006, 3, 0};
        tbl[12] = '{0, 0, 16'h0000, 0, 16'h0000, 0, 1};
        tbl[13] = '{0, 0, 16'h0000, 1, 16'h0040, 0, 1};
        tbl[14] = '{0, 0, 16'h0000, 1, 16'h0041, 0, 1};
`else
        tbl[0]  = '{0, 0, 16'h0000, 0, 16'h0000, 0, 1};
        tbl[1]  = '{0, 0, 16'h0000, 0, 16'h0000, 0, 1};
        tbl[2]  = '{0, 0, 16'h0000, 1, 16'h0000, 1, 1};
        tbl[3]  = '{0, 0, 16'h0000, 1, 16'h0001, 1, 1};
        tbl[4]  = '{1, 0, 16'h0000, 1, 16'h0002, 1, 1};
        tbl[5]  = '{1, 0, 16'h0000, 1, 16'h0002, 2, 1};
        tbl[6]  = '{1, 0, 16'h0000, 1, 16'h0002, 3, 0};
        tbl[7]  = '{1, 0, 16'h0000, 1, 16'h0002, 4, 0};
        tbl[8]  = '{0, 0, 16'h0000, 1, 16'h0002, 4, 1};
        tbl[9]  = '{0, 0, 16'h0000, 1, 16'h0003, 3, 1};
        tbl[10] = '{0, 0, 16'h0000, 1, 16'h0004, 3, 1};
        tbl[11] = '{0, 1, 16'h0040, 1, 16'h0005, 3, 0};
        tbl[12] = '{0, 0, 16'h0000, 0, 16'h0000, 0, 1};
        tbl[13] = '{0, 0, 16'h0000, 0, 16'h0000, 0, 1};
        tbl[14] = '{0, 0, 16'h0000, 1, 16'h0040, 1, 1};
`endif
        wrap_exp[0] = 16'hFFFE;
        wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000;
        wrap_exp[3] = 16'h0001;

        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rdata  = '0;
        modelReset();

        // reset held: everything idle, no fetch issued
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("in reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] reset released, running vector table");

        // start-up, stall to credit exhaustion, release, redirect
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].s, tbl[i].r, tbl[i].rpc);
            checkOutput($sformatf("tbl[%0d] valid", i), 32'(obs_valid), 32'(tbl[i].v));
            checkOutput($sformatf("tbl[%0d] pcD", i), 32'(obs_pcd), tbl[i].v ? 32'(tbl[i].pcd) : 32'd0);
            checkOutput($sformatf("tbl[%0d] count", i), 32'(obs_count), 32'(tbl[i].cnt));
            checkOutput($sformatf("tbl[%0d] imem_en", i), 32'(obs_en), 32'(tbl[i].en));
        end

        // PC wraps across the top of the address space
        $display("[TB] wrap sequence");
        applyStimulus(1'b0, 1'b1, 16'hFFFE);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            if (obs_valid) seen.push_back(obs_pcd);
        end
        checkOutput("wrap seen", 32'(seen.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size())
                checkOutput($sformatf("wrap pcD[%0d]", i), 32'(seen[i]), 32'(wrap_exp[i]));
        end

        // randomized traffic with bursts of heavy stalling
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            s   = ((i % 100) < 30) ? ($urandom_range(99) < 85) : ($urandom_range(99) < 35);
            r   = ($urandom_range(99) < 5);
            rpc = ($urandom_range(3) == 0) ? ADDR_W'(16'hFFFC + $urandom_range(3)) : ADDR_W'($urandom);
            applyStimulus(s, r, rpc);
        end

        // fill the queue under stall, then hit it with an asynchronous reset mid-cycle
        $display("[TB] async reset with queue full");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("full before reset", 32'(count), 32'(DEPTH));
        #2;
        reset = 1'b1;
        #1;
        checkIdleOutputs("async reset");
        @(posedge clk);
        #1;
        reset      = 1'b0;
        imem_rdata = INSTR_W'($urandom);
        modelReset();
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
